bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_to_bin_seq.sv | 137 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential display-code to signed binary converter: walks the latched word
// most significant digit first, one digit per clock, then saturates the result.
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned OUT_W  = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    bin_out,
  output logic                ovf
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ACC_W = OUT_W + 4;
  localparam int unsigned PW    = OUT_W + 8;

  localparam logic [PW-1:0]    LIM     = {{(PW-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] MAX_POS = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                sticky_q, sticky_d;
  logic                neg_q, neg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    bin_q, bin_d;
  logic                ovf_q, ovf_d;

  logic [3:0]    code;
  logic [3:0]    digit_val;
  logic [PW-1:0] acc_next;
  logic          pos_ovf;

  // The latched word shifts left each CONV cycle, so the current digit is
  // always the top nibble; idx only counts the remaining digits.
  assign code      = bcd_q[4*DIGITS-1 -: 4];
  assign digit_val = (code <= 4'd9) ? code : 4'd0;
  assign acc_next  = {1'b0, acc_q, 3'b000} + {3'b000, acc_q, 1'b0}
                   + {{(PW-4){1'b0}}, digit_val};
  assign pos_ovf   = sticky_q | (acc_q > MAX_POS);

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    neg_d       = neg_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    bin_d       = bin_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bcd_d    = bcd_in;
          acc_d    = '0;
          sticky_d = 1'b0;
          neg_d    = 1'b0;
          idx_d    = IDX_W'(DIGITS - 1);
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        bcd_d    = bcd_q << 4;
        acc_d    = acc_next[ACC_W-1:0];
        sticky_d = sticky_q | (acc_next > LIM);
        if (code == 4'hE) neg_d = ~neg_q;
        if (idx_q == '0) state_d = S_FIN;
        else             idx_d   = idx_q - IDX_W'(1);
      end
      S_FIN: begin
        // Once sticky is set acc may have wrapped, so it must not be trusted.
        if (neg_q) begin
          ovf_d = sticky_q;
          bin_d = sticky_q ? MIN_NEG : -acc_q[OUT_W-1:0];
        end else begin
          ovf_d = pos_ovf;
          bin_d = pos_ovf ? MAX_OUT : acc_q[OUT_W-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bcd_q       <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      neg_q       <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      neg_q       <= neg_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a 4-digit and a 5-digit instance share stimulus,
// one is active at a time (sel), and results are checked against a decimal model.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sel;
  logic [19:0] bcd_in;

  logic        iv4, iv5;
  logic        ir4, ov4, ovf4;
  logic        ir5, ov5, ovf5;
  logic [10:0] b4, b5;

  logic        cur_in_ready, cur_out_valid, cur_ovf, cur_in_valid;
  logic [10:0] cur_bin;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned cyc     = 0;
  logic        prev_ov = 1'b0;

  typedef struct {
    logic [10:0] b;
    logic        o;
    int unsigned cyc;
    int unsigned nd;
  } exp_t;
  exp_t q[$];

  assign iv4 = in_valid & ~sel;
  assign iv5 = in_valid & sel;
  assign cur_in_valid  = sel ? iv5 : iv4;
  assign cur_in_ready  = sel ? ir5 : ir4;
  assign cur_out_valid = sel ? ov5 : ov4;
  assign cur_bin       = sel ? b5  : b4;
  assign cur_ovf       = sel ? ovf5 : ovf4;

  bcd_to_bin_seq #(.DIGITS(4), .OUT_W(11)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .bcd_in(bcd_in[15:0]), .out_valid(ov4), .out_ready(out_ready),
    .bin_out(b4), .ovf(ovf4)
  );

  bcd_to_bin_seq #(.DIGITS(5), .OUT_W(11)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5),
    .bcd_in(bcd_in), .out_valid(ov5), .out_ready(out_ready),
    .bin_out(b5), .ovf(ovf5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic timeout_fail(input string nm);
    n_total++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Decimal model: sum digit values by weight, parity of minus signs, clamp.
  function automatic void model(input logic [19:0] w, input int unsigned nd,
                                output logic [10:0] b, output logic o);
    longint     mag;
    bit         neg;
    logic [3:0] c;
    mag = 0;
    neg = 0;
    for (int i = 0; i < int'(nd); i++) begin
      c = w[4*i +: 4];
      if (c <= 4'd9) mag = mag + longint'(c) * (10 ** i);
      if (c == 4'hE) neg = !neg;
    end
    if (neg) begin
      if (mag > 1024) begin b = 11'h400; o = 1'b1; end
      else begin b = 11'(-mag); o = 1'b0; end
    end else begin
      if (mag > 1023) begin b = 11'h3FF; o = 1'b1; end
      else begin b = 11'(mag); o = 1'b0; end
    end
  endfunction

  function automatic logic [19:0] rand_word();
    logic [19:0] w;
    int unsigned r;
    w = '0;
    for (int i = 0; i < 5; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      w[4*i +: 4] = 4'($urandom_range(0, 9));
      else if (r < 9) w[4*i +: 4] = 4'hE;
      else            w[4*i +: 4] = 4'($urandom_range(10, 15));
    end
    return w;
  endfunction

  // Compare process: inputs change only just after posedges, so everything
  // sampled here is what the next posedge will see.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      prev_ov = 1'b0;
    end else begin
      if (q.size() == 0) begin
        chk("idle_out_valid", 32'(cur_out_valid), 32'd0);
        chk("idle_in_ready", 32'(cur_in_ready), 32'd1);
      end else begin
        chk("busy_in_ready", 32'(cur_in_ready), 32'd0);
        if (cur_out_valid) begin
          if (!prev_ov) chk("latency", cyc - q[0].cyc, q[0].nd + 2);
          chk("bin_out", 32'(cur_bin), 32'(q[0].b));
          chk("ovf", 32'(cur_ovf), 32'(q[0].o));
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = cur_out_valid;
      if (cur_in_valid && cur_in_ready) begin
        e.nd  = sel ? 5 : 4;
        model(bcd_in, e.nd, e.b, e.o);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic do_txn(input logic s, input logic [19:0] w, input int unsigned hold,
                        input bit stray, input bit lit, input logic [10:0] eb, input logic eo);
    int unsigned t;
    logic [10:0] b0;
    @(posedge clk); #1;
    sel      = s;
    bcd_in   = w;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!cur_in_ready && t < 50) begin t++; @(negedge clk); end
    if (!cur_in_ready) begin
      timeout_fail("accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    bcd_in   = 20'($urandom);
    t = 0;
    @(negedge clk);
    while (!cur_out_valid && t < 50) begin t++; @(negedge clk); end
    if (!cur_out_valid) begin
      timeout_fail("out_valid");
      return;
    end
    b0 = cur_bin;
    if (lit) begin
      chk("lit_bin", 32'(cur_bin), 32'(eb));
      chk("lit_ovf", 32'(cur_ovf), 32'(eo));
    end
    for (int unsigned k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (stray) begin bcd_in = 20'h00001; in_valid = 1'b1; end
      @(negedge clk);
      chk("hold_in_ready", 32'(cur_in_ready), 32'd0);
      chk("hold_bin", 32'(cur_bin), 32'(b0));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("release_out_valid", 32'(cur_out_valid), 32'd0);
    chk("release_in_ready", 32'(cur_in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
    bcd_in    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready4", 32'(ir4), 32'd1);
    chk("rst_out_valid4", 32'(ov4), 32'd0);
    chk("rst_bin4", 32'(b4), 32'd0);
    chk("rst_ovf4", 32'(ovf4), 32'd0);
    chk("rst_in_ready5", 32'(ir5), 32'd1);
    chk("rst_out_valid5", 32'(ov5), 32'd0);
    chk("rst_bin5", 32'(b5), 32'd0);
    chk("rst_ovf5", 32'(ovf5), 32'd0);

    do_txn(1'b0, 20'h00123, 0, 0, 1, 11'h07B, 1'b0);
    do_txn(1'b0, 20'h0E042, 0, 0, 1, 11'h7D6, 1'b0);
    do_txn(1'b0, 20'h0EE12, 0, 0, 1, 11'h00C, 1'b0);
    do_txn(1'b0, 20'h0F5F7, 0, 0, 1, 11'h1FB, 1'b0);
    do_txn(1'b0, 20'h01024, 0, 0, 1, 11'h3FF, 1'b1);
    do_txn(1'b0, 20'h00000, 0, 0, 1, 11'h000, 1'b0);
    do_txn(1'b0, 20'h0E000, 0, 0, 1, 11'h000, 1'b0);
    // backpressure with a stray request that must be ignored
    do_txn(1'b0, 20'h00456, 3, 1, 1, 11'h1C8, 1'b0);
    do_txn(1'b1, 20'hE1024, 0, 0, 1, 11'h400, 1'b0);
    do_txn(1'b1, 20'hE1025, 0, 0, 1, 11'h400, 1'b1);
    do_txn(1'b1, 20'h99999, 0, 0, 1, 11'h3FF, 1'b1);
    do_txn(1'b1, 20'h01023, 0, 0, 1, 11'h3FF, 1'b0);

    // reset two cycles into conversion
    @(posedge clk); #1;
    sel      = 1'b0;
    bcd_in   = 20'h00999;
    in_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(ir4), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(ir4), 32'd1);
    chk("mid_rst_out_valid", 32'(ov4), 32'd0);
    chk("mid_rst_bin", 32'(b4), 32'd0);
    repeat (8) @(posedge clk);
    do_txn(1'b0, 20'h00007, 0, 0, 1, 11'h007, 1'b0);

    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom_range(0, 1)), rand_word(), $urandom_range(0, 3),
             bit'($urandom_range(0, 1)), 0, 11'h000, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
